// File: rtl/shift_reg_controller_if.sv
// Command/handshake and register-control bundle between a shift-register controller and its user.
// The master side issues commands and returns register contents. The slave side is the controller.
interface shift_reg_controller_if #(
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_load;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_count;
  logic [N-1:0]     cmd_data;
  logic             cmd_abort;
  logic [1:0]       sr_ctrl;
  logic [N-1:0]     sr_data;
  logic [N-1:0]     sr_q;
  logic             busy;
  logic             done;
  logic [N-1:0]     result;

  modport master (
    output cmd_valid, cmd_load, cmd_dir, cmd_count, cmd_data, cmd_abort, sr_q,
    input  cmd_ready, sr_ctrl, sr_data, busy, done, result
  );

  modport slave (
    input  cmd_valid, cmd_load, cmd_dir, cmd_count, cmd_data, cmd_abort, sr_q,
    output cmd_ready, sr_ctrl, sr_data, busy, done, result
  );
endinterface

// File: rtl/shift_reg_controller.sv
// Sequences an external N-bit shift register: optional parallel load, then count single-bit shifts,
// then captures the register contents and pulses done. Fixed latency, abortable, one command at a time.
module shift_reg_controller #(
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  shift_reg_controller_if.slave bus
);

  localparam int unsigned ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] CTRL_HOLD = 2'b00;
  localparam logic [1:0] CTRL_SHL  = 2'b01;
  localparam logic [1:0] CTRL_SHR  = 2'b10;
  localparam logic [1:0] CTRL_LOAD = 2'b11;

  state_t           r_state;
  state_t           w_next;
  logic             r_dir;
  logic [CNT_W-1:0] r_cnt;
  logic [N-1:0]     r_sr_data;
  logic [N-1:0]     r_result;
  logic             r_done;
  logic             w_accept;
  logic             w_abort;
  logic             w_complete;

  // Abort only means something while a command is in flight.
  assign w_accept   = bus.cmd_valid && (r_state == S_IDLE);
  assign w_abort    = bus.cmd_abort && (r_state != S_IDLE);
  assign w_complete = (r_state == S_DONE) && !w_abort;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            if (bus.cmd_load)                 w_next = S_LOAD;
            else if (bus.cmd_count != '0)     w_next = S_SHIFT;
            else                              w_next = S_DONE;
          end
        end
        S_LOAD:  w_next = (r_cnt != '0) ? S_SHIFT : S_DONE;
        S_SHIFT: if (r_cnt <= CNT_W'(1)) w_next = S_DONE;
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.sr_ctrl   = CTRL_HOLD;
    bus.cmd_ready = 1'b0;
    bus.busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        bus.busy      = 1'b0;
      end
      S_LOAD:  bus.sr_ctrl = CTRL_LOAD;
      S_SHIFT: bus.sr_ctrl = r_dir ? CTRL_SHR : CTRL_SHL;
      default: bus.sr_ctrl = CTRL_HOLD;
    endcase
    if (w_abort) bus.sr_ctrl = CTRL_HOLD;
  end

  // Command latch and shift down-counter; the counter only moves while shifting.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_dir     <= 1'b0;
      r_cnt     <= '0;
      r_sr_data <= '0;
    end else if (w_accept) begin
      r_dir     <= bus.cmd_dir;
      r_cnt     <= bus.cmd_count;
      r_sr_data <= bus.cmd_data;
    end else if ((r_state == S_SHIFT) && !w_abort) begin
      r_cnt     <= r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= w_complete;
      if (w_complete) r_result <= bus.sr_q;
    end
  end

  assign bus.sr_data = r_sr_data;
  assign bus.done    = r_done;
  assign bus.result  = r_result;

endmodule

// File: tb/tb_shift_reg_controller.sv
// Bench for shift_reg_controller: directed vector table, random commands against a shift-arithmetic
// model, and a mid-command reset sequence, with a behavioural shift register closing the loop.
module tb_shift_reg_controller;

  localparam int unsigned N     = 8;
  localparam int unsigned CNT_W = 4;

  logic clk;
  logic reset;

  shift_reg_controller_if #(.N(N), .CNT_W(CNT_W)) bus ();

  shift_reg_controller #(.N(N), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural shift register driven by sr_ctrl, with a bench-side preset.
  logic [N-1:0] q;
  logic         preset_en;
  logic [N-1:0] preset_val;

  always @(posedge clk) begin
    if (preset_en) q <= preset_val;
    else begin
      case (bus.sr_ctrl)
        2'b01:   q <= {q[N-2:0], 1'b0};
        2'b10:   q <= {1'b0, q[N-1:1]};
        2'b11:   q <= bus.sr_data;
        default: q <= q;
      endcase
    end
  end
  assign bus.sr_q = q;

  int           errors;
  int           checks;
  logic [N-1:0] res_hold;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] model_result(input logic [N-1:0] start, input logic dr, input int c);
    logic [N-1:0] v;
    v = start;
    for (int i = 0; i < c; i++) v = dr ? (v / 2) : N'(int'(v) * 2);
    return v;
  endfunction

  // Called at a negedge in a cycle where the controller is IDLE. Returns in the done cycle
  // (or the cycle after an abort) with cmd_valid low, so consecutive calls are back-to-back.
  task automatic do_cmd(input logic ld, input logic dr, input logic [CNT_W-1:0] cnt,
                        input logic [N-1:0] dat, input int abort_cyc,
                        input logic [N-1:0] exp_res, input string nm);
    int         nb;
    logic [1:0] exp_ctrl;
    nb = int'(ld) + int'(cnt) + 1;
    chk({nm, ":ready"}, 32'(bus.cmd_ready), 32'(1));
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = ld;
    bus.cmd_dir   = dr;
    bus.cmd_count = cnt;
    bus.cmd_data  = dat;
    @(negedge clk);
    for (int k = 0; k < nb; k++) begin
      if (ld && k == 0)   exp_ctrl = 2'b11;
      else if (k < nb - 1) exp_ctrl = dr ? 2'b10 : 2'b01;
      else                 exp_ctrl = 2'b00;
      chk({nm, ":busy"},  32'(bus.busy),      32'(1));
      chk({nm, ":done0"}, 32'(bus.done),      32'(0));
      chk({nm, ":nrdy"},  32'(bus.cmd_ready), 32'(0));
      if (k == 0) chk({nm, ":sr_data"}, 32'(bus.sr_data), 32'(dat));
      if (k == abort_cyc) begin
        bus.cmd_valid = 1'b0;
        bus.cmd_abort = 1'b1;
        #1;
        chk({nm, ":abort_ctrl"}, 32'(bus.sr_ctrl), 32'(0));
        @(negedge clk);
        bus.cmd_abort = 1'b0;
        chk({nm, ":abort_busy"}, 32'(bus.busy),   32'(0));
        chk({nm, ":abort_done"}, 32'(bus.done),   32'(0));
        chk({nm, ":abort_res"},  32'(bus.result), 32'(res_hold));
        return;
      end
      chk({nm, ":ctrl"}, 32'(bus.sr_ctrl), 32'(exp_ctrl));
      // Commands offered while busy must be ignored.
      bus.cmd_valid = (k < nb - 1) ? 1'($urandom) : 1'b0;
      bus.cmd_load  = 1'($urandom);
      bus.cmd_dir   = 1'($urandom);
      bus.cmd_count = CNT_W'($urandom);
      bus.cmd_data  = N'($urandom);
      @(negedge clk);
    end
    chk({nm, ":done"},   32'(bus.done),      32'(1));
    chk({nm, ":result"}, 32'(bus.result),    32'(exp_res));
    chk({nm, ":idle"},   32'(bus.busy),      32'(0));
    chk({nm, ":rdy"},    32'(bus.cmd_ready), 32'(1));
    res_hold = exp_res;
  endtask

  typedef struct {
    logic             ld;
    logic             dr;
    logic [CNT_W-1:0] cnt;
    logic [N-1:0]     dat;
    logic             pre;
    logic [N-1:0]     pre_val;
    int               abort_cyc;
    logic [N-1:0]     exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    errors        = 0;
    checks        = 0;
    res_hold      = '0;
    q             = '0;
    preset_en     = 1'b0;
    preset_val    = '0;
    reset         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_load  = 1'b0;
    bus.cmd_dir   = 1'b0;
    bus.cmd_count = '0;
    bus.cmd_data  = '0;
    bus.cmd_abort = 1'b0;

    vecs[0] = '{1'b1, 1'b0, 4'd3,  8'hA5, 1'b0, 8'h00, -1, 8'h28};
    vecs[1] = '{1'b0, 1'b1, 4'd2,  8'h00, 1'b1, 8'h80, -1, 8'h20};
    vecs[2] = '{1'b1, 1'b0, 4'd0,  8'h3C, 1'b0, 8'h00, -1, 8'h3C};
    vecs[3] = '{1'b1, 1'b0, 4'd15, 8'hFF, 1'b0, 8'h00, -1, 8'h00};
    vecs[4] = '{1'b1, 1'b0, 4'd5,  8'h0F, 1'b0, 8'h00,  2, 8'h00};
    vecs[5] = '{1'b0, 1'b0, 4'd0,  8'h77, 1'b0, 8'h00, -1, 8'h1E};
    vecs[6] = '{1'b1, 1'b1, 4'd4,  8'hC3, 1'b0, 8'h00, -1, 8'h0C};
    vecs[7] = '{1'b1, 1'b0, 4'd9,  8'h81, 1'b0, 8'h00, -1, 8'h00};

    // Reset state; a command offered during reset must not be taken.
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst:ready",   32'(bus.cmd_ready), 32'(1));
    chk("rst:busy",    32'(bus.busy),      32'(0));
    chk("rst:done",    32'(bus.done),      32'(0));
    chk("rst:ctrl",    32'(bus.sr_ctrl),   32'(0));
    chk("rst:sr_data", 32'(bus.sr_data),   32'(0));
    chk("rst:result",  32'(bus.result),    32'(0));
    bus.cmd_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].pre) begin
        preset_en  = 1'b1;
        preset_val = vecs[i].pre_val;
        @(negedge clk);
        preset_en  = 1'b0;
      end
      do_cmd(vecs[i].ld, vecs[i].dr, vecs[i].cnt, vecs[i].dat, vecs[i].abort_cyc,
             vecs[i].exp, $sformatf("vec%0d", i));
    end
    @(negedge clk);
    chk("vec:done_fall", 32'(bus.done), 32'(0));

    // Randomised commands against the shift-arithmetic model.
    for (int i = 0; i < 40; i++) begin
      logic             ld;
      logic             dr;
      logic [CNT_W-1:0] cnt;
      logic [N-1:0]     dat;
      int               ab;
      int               gap;
      ld  = 1'($urandom);
      dr  = 1'($urandom);
      cnt = CNT_W'($urandom);
      dat = N'($urandom);
      ab  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, int'(ld) + int'(cnt))) : -1;
      do_cmd(ld, dr, cnt, dat, ab, model_result(ld ? dat : q, dr, int'(cnt)),
             $sformatf("rnd%0d", i));
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk("rnd:gap_done", 32'(bus.done), 32'(0));
      end
    end

    // Reset mid-SHIFT: abandon, no done, everything back to reset values.
    preset_en  = 1'b1;
    preset_val = 8'h00;
    @(negedge clk);
    preset_en  = 1'b0;
    do_cmd(1'b1, 1'b0, 4'd0, 8'h5A, -1, 8'h5A, "pre_rst");
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = 1'b1;
    bus.cmd_dir   = 1'b0;
    bus.cmd_count = 4'd6;
    bus.cmd_data  = 8'h55;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mrst:ctrl_pre", 32'(bus.sr_ctrl), 32'(1));
    reset = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_abort = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_abort = 1'b0;
    chk("mrst:ready",   32'(bus.cmd_ready), 32'(1));
    chk("mrst:busy",    32'(bus.busy),      32'(0));
    chk("mrst:done",    32'(bus.done),      32'(0));
    chk("mrst:ctrl",    32'(bus.sr_ctrl),   32'(0));
    chk("mrst:sr_data", 32'(bus.sr_data),   32'(0));
    chk("mrst:result",  32'(bus.result),    32'(0));
    reset = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("mrst:no_done", 32'(bus.done), 32'(0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_reg_controller.md
SHIFT_REG_CONTROLLER -- requirements
Module: shift_reg_controller

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the width of the controlled shift register.
REQ-002 The block SHALL have parameter CNT_W, default 4, giving the width of the shift-count field.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset, sampled on rising clk).
REQ-005 The block SHALL have port cmd_valid, input, 1 bit: command present.
REQ-006 The block SHALL have port cmd_ready, output, 1 bit: the block accepts a command this cycle.
REQ-007 The block SHALL have port cmd_load, input, 1 bit: load cmd_data before shifting.
REQ-008 The block SHALL have port cmd_dir, input, 1 bit: 0 = shift toward MSB, 1 = shift toward LSB.
REQ-009 The block SHALL have port cmd_count, input, CNT_W bits: number of single-bit shifts, 0 to 2^CNT_W-1.
REQ-010 The block SHALL have port cmd_data, input, N bits: parallel load value.
REQ-011 The block SHALL have port cmd_abort, input, 1 bit: cancel the command in progress.
REQ-012 The block SHALL have port sr_ctrl, output, 2 bits: register control, encoded 00 hold, 01 {q[N-2:0],0}, 10 {0,q[N-1:1]}, 11 parallel load.
REQ-013 The block SHALL have port sr_data, output, N bits: parallel-load value presented to the register.
REQ-014 The block SHALL have port sr_q, input, N bits: current register contents.
REQ-015 The block SHALL have port busy, output, 1 bit: a command is in progress (state not IDLE).
REQ-016 The block SHALL have port done, output, 1 bit: registered one-cycle completion pulse.
REQ-017 The block SHALL have port result, output, N bits: register contents captured at completion, held until the next completion.

Function
REQ-018 The block SHALL implement FSM states IDLE, LOAD, SHIFT and DONE, with sr_ctrl decoded from state as IDLE 00, LOAD 11, SHIFT 01 (dir=0) or 10 (dir=1), DONE 00.
REQ-019 cmd_ready SHALL equal (state==IDLE); a command is accepted on the rising edge where cmd_valid and cmd_ready are both 1.
REQ-020 On accept, the block SHALL latch cmd_load, cmd_dir, cmd_count into a down-counter and cmd_data into sr_data; sr_data SHALL hold that value until the next accept.
REQ-021 The accept transition SHALL be IDLE to LOAD if cmd_load=1, else to SHIFT if cmd_count>0, else to DONE.
REQ-022 LOAD SHALL last exactly one cycle, then go to SHIFT if count>0, else to DONE.
REQ-023 SHIFT SHALL last exactly count cycles (one shift per cycle, counter decremented each edge), then go to DONE.
REQ-024 DONE SHALL last one cycle and then go to IDLE; on that edge result<=sr_q and done<=1.
REQ-025 done SHALL be 1 for exactly one cycle per completed command and 0 otherwise.
REQ-026 Latency SHALL be fixed: done is high in the cycle following edge (L+count+1) after the accept edge, where L = cmd_load.
REQ-027 cmd_valid while busy SHALL be ignored; no command is queued.
REQ-028 A new command SHALL be acceptable in the same cycle done is high (back-to-back).
REQ-029 count > N SHALL be legal, with the register simply shifting to all zeros; no saturation or error is raised.
REQ-030 cmd_abort=1 in LOAD, SHIFT or DONE SHALL force sr_ctrl=00 that cycle and IDLE on the next edge, with no done and result unchanged.
REQ-031 cmd_abort SHALL be ignored in IDLE, and abort SHALL win over accept if both occur.
REQ-032 The block SHALL not observe sr_q except for the capture in DONE.

Reset
REQ-033 With reset=0 at a rising edge, the block SHALL set state IDLE, sr_ctrl 00, sr_data 0, counter 0, result 0, done 0 and busy 0, so that cmd_ready=1 after that edge.
REQ-034 Reset asserted mid-command SHALL abandon the command with no done pulse, and reset SHALL take priority over abort and accept.

Verification (N=8, CNT_W=4, controller driving a behavioural register model)
REQ-035 Load 0xA5, dir 0, count 3 -> sr_ctrl sequence 11,01,01,01,00; done high cycle after 5th edge; result 0x28.
REQ-036 Register preset 0x80, no load, dir 1, count 2 -> result 0x20; done after 3rd edge.
REQ-037 Load 0x3C, count 0 -> sr_ctrl 11,00; result 0x3C; done after 2nd edge; next command accepted while done=1.
REQ-038 Load 0xFF, dir 0, count 15 -> result 0x00; busy high for 17 cycles.
REQ-039 Abort in 2nd SHIFT cycle of a count-5 command -> sr_ctrl 00 that cycle, IDLE next edge, no done, result unchanged; cmd_valid during busy ignored.
REQ-040 reset=0 during SHIFT -> next edge all outputs at reset values, no done, cmd_ready=1.
